// File: rtl/fmap_buf_ctrl.sv
// +--------------------------------------------------------------------------+
// | fmap_buf_ctrl: fills a ROWSxCOLS feature-map buffer in raster order,     |
// | then drains it to the consumer.                       Revision: 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module fmap_buf_ctrl #(
  parameter int DW   = 8,
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_addr1,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [AW-1:0] c_last_row = AW'(ROWS - 1);
  localparam logic [AW-1:0] c_last_col = AW'(COLS - 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_col;
  logic          r_frame_done;

  logic [1:0]    w_state_nxt;
  logic [AW-1:0] w_row_nxt;
  logic [AW-1:0] w_col_nxt;
  logic          w_done_nxt;
  logic          w_at_end;
  logic          w_xfer;

  assign w_at_end = (r_row == c_last_row) && (r_col == c_last_col);
  // One pixel moves this cycle in whichever direction the state points.
  assign w_xfer   = ((r_state == S_FILL) && in_valid) || ((r_state == S_DRAIN) && out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_done_nxt  = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_row_nxt   = '0;
      w_col_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_FILL;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
          end
        end
        S_FILL, S_DRAIN: begin
          if (w_xfer) begin
            if (w_at_end) begin
              w_state_nxt = (r_state == S_FILL) ? S_DRAIN : S_IDLE;
              w_row_nxt   = '0;
              w_col_nxt   = '0;
              w_done_nxt  = (r_state == S_DRAIN);
            end else if (r_col == c_last_col) begin
              w_col_nxt = '0;
              w_row_nxt = r_row + AW'(1);
            end else begin
              w_col_nxt = r_col + AW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    case (r_state)
      S_FILL: begin
        in_ready  = 1'b1;
        mem_wr_en = in_valid & ~abort;
      end
      S_DRAIN: begin
        mem_rd_en = 1'b1;
        out_valid = 1'b1;
        out_data  = mem_rdata;
        out_last  = w_at_end;
      end
      default: begin
        in_ready  = 1'b0;
      end
    endcase
  end

  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign mem_addr   = r_row;
  assign mem_addr1  = r_col;
  assign mem_wdata  = in_data;

endmodule

`default_nettype wire
